// File: rtl/alu_flag_stage_if.sv
// Handshake bundle between the ALU, the flag stage and writeback.
// The ALU/writeback side uses master; the flag stage uses slave.
interface alu_flag_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEST_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_c_out;
  logic [3:0]        in_sel;
  logic              in_a_sign;
  logic              in_b_sign;
  logic [DEST_W-1:0] in_dest;
  logic              in_flag_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [DEST_W-1:0] out_dest;
  logic [3:0]        out_flags;

  modport master (
    output in_valid, in_result, in_c_out, in_sel, in_a_sign, in_b_sign, in_dest, in_flag_we,
    output out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_c_out, in_sel, in_a_sign, in_b_sign, in_dest, in_flag_we,
    input  out_ready,
    output in_ready, out_valid, out_result, out_dest, out_flags
  );
endinterface

// File: rtl/alu_flag_stage.sv
// ALU execute-to-writeback stage: derives Z/N/C/V, holds the architectural flags
// and buffers up to two results in a FIFO-ordered elastic buffer.
module alu_flag_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEST_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_flag_stage_if.slave  bus,
  output logic [3:0]       flags,
  output logic             carry_fb
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] result_q [2];
  logic [DEST_W-1:0] dest_q   [2];
  logic [3:0]        eflags_q [2];
  logic [3:0]        flags_q;
  logic              accept, pop;
  logic              z, n, c, v;
  logic              a_s, b_s;

  assign bus.in_ready  = (state_q != StTwo) && !flush;
  assign bus.out_valid = (state_q != StEmpty);
  assign accept        = bus.in_valid && bus.in_ready;
  // A pop presented during a flush is discarded along with the entries.
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  assign bus.out_result = result_q[rd_ptr_q];
  assign bus.out_dest   = dest_q[rd_ptr_q];
  assign bus.out_flags  = eflags_q[rd_ptr_q];
  assign flags          = flags_q;
  assign carry_fb       = flags_q[1];

  assign a_s = bus.in_a_sign;
  assign b_s = bus.in_b_sign;

  always_comb begin
    z = (bus.in_result == '0);
    n = bus.in_result[DATA_W-1];
    c = flags_q[1];
    v = 1'b0;
    case (bus.in_sel)
      4'b0000: begin
        c = bus.in_c_out;
        v = (a_s == b_s) && (n != a_s);
      end
      4'b0001: begin
        c = bus.in_c_out;
        v = (a_s != b_s) && (n != a_s);
      end
      4'b1101: begin
        c = bus.in_c_out;
        v = (b_s != a_s) && (n != b_s);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ accept;
    rd_ptr_d = rd_ptr_q ^ pop;
    if (flush) begin
      state_d  = StEmpty;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !pop)      state_d = StTwo;
          else if (pop && !accept) state_d = StEmpty;
        end
        StTwo:   if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Flags commit on accept so a chained op sees the new carry next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      for (int i = 0; i < 2; i++) begin
        result_q[i] <= '0;
        dest_q[i]   <= '0;
        eflags_q[i] <= 4'b0000;
      end
    end else if (accept) begin
      result_q[wr_ptr_q] <= bus.in_result;
      dest_q[wr_ptr_q]   <= bus.in_dest;
      eflags_q[wr_ptr_q] <= {z, n, c, v};
      if (bus.in_flag_we) flags_q <= {z, n, c, v};
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed plus randomized checks of alu_flag_stage against a queue-based model.
module tb_alu_flag_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] flags;
  logic       carry_fb;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [15:0] r;
    logic [3:0]  d;
    logic [3:0]  f;
  } ent_t;

  ent_t       q[$];
  logic [3:0] mflags = 4'b0000;
  logic [3:0] saved;

  alu_flag_stage_if #(.DATA_W(16), .DEST_W(4)) bus ();

  alu_flag_stage #(.DATA_W(16), .DEST_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .flags    (flags),
    .carry_fb (carry_fb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flag rules written directly from the architectural definition.
  function automatic logic [3:0] derive(input logic [15:0] r, input logic co, input logic [3:0] sel,
                                        input logic as, input logic bs, input logic cur_c);
    logic zf, nf, cf, vf;
    zf = (r == 16'h0000);
    nf = r[15];
    cf = cur_c;
    vf = 1'b0;
    if (sel == 4'd0)  begin cf = co; vf = (as == bs) && (nf != as); end
    if (sel == 4'd1)  begin cf = co; vf = (as != bs) && (nf != as); end
    if (sel == 4'd13) begin cf = co; vf = (bs != as) && (nf != bs); end
    return {zf, nf, cf, vf};
  endfunction

  // Check the visible state against the model, then advance one clock edge.
  task automatic step();
    logic exp_rdy, acc, pop;
    logic [3:0] f;
    #1;
    exp_rdy = (q.size() < 2) && !flush;
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", bus.out_result, q[0].r);
      chk("out_dest", bus.out_dest, q[0].d);
      chk("out_flags", bus.out_flags, q[0].f);
    end
    chk("flags", flags, mflags);
    chk("carry_fb", carry_fb, mflags[1]);
    acc = bus.in_valid && exp_rdy;
    pop = (q.size() != 0) && bus.out_ready && !flush;
    f = derive(bus.in_result, bus.in_c_out, bus.in_sel, bus.in_a_sign, bus.in_b_sign, mflags[1]);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{r: bus.in_result, d: bus.in_dest, f: f});
    end
    if (acc && bus.in_flag_we) mflags = f;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [15:0] r, input logic co,
                       input logic as, input logic bs, input logic [3:0] dest, input logic we);
    bus.in_valid   = 1'b1;
    bus.in_sel     = sel;
    bus.in_result  = r;
    bus.in_c_out   = co;
    bus.in_a_sign  = as;
    bus.in_b_sign  = bs;
    bus.in_dest    = dest;
    bus.in_flag_we = we;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_c_out = 1'b0; bus.in_sel = '0;
    bus.in_a_sign = 1'b0; bus.in_b_sign = 1'b0; bus.in_dest = '0; bus.in_flag_we = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_dest", bus.out_dest, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    chk("rst_flags", flags, 0);
    chk("rst_carry_fb", carry_fb, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Add overflow
    drive(4'd0, 16'h8000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
    chk("ovf_flags", bus.out_flags, 4'b0101);
    chk("ovf_dest", bus.out_dest, 3);
    chk("ovf_carry", carry_fb, 0);
    step();

    // Carry feedback and preserved C
    drive(4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    chk("cf_first_flags", bus.out_flags, 4'b1010);
    chk("cf_carry", carry_fb, 1);
    drive(4'd2, 16'h00F0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    chk("cf_second_flags", bus.out_flags, 4'b0010);
    step();

    // Backpressure
    bus.out_ready = 1'b0;
    drive(4'd2, 16'd1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
    drive(4'd2, 16'd2, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0);
    #1;
    chk("bp_full", bus.in_ready, 0);
    chk("bp_head", bus.out_result, 1);
    bus.out_ready = 1'b1;
    step();
    chk("bp_ready_back", bus.in_ready, 1);
    chk("bp_second", bus.out_result, 2);
    step();
    chk("bp_drained", bus.out_valid, 0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      drive(4'd2, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b0);
      chk("stream_head", bus.out_result, 16'h0100 + i);
    end
    step();

    // Flush while full with an input presented
    bus.out_ready = 1'b0;
    drive(4'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1);
    drive(4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0);
    saved = mflags;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    step();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_flags", flags, saved);

    // Asynchronous reset between edges
    drive(4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd8, 1'b1);
    chk("ar_flags_pre", flags, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_flags", flags, 0);
    chk("ar_carry", carry_fb, 0);
    q.delete();
    mflags = 4'b0000;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       bus.in_sel = 4'd0;
        1:       bus.in_sel = 4'd1;
        2:       bus.in_sel = 4'd13;
        default: bus.in_sel = 4'($urandom);
      endcase
      bus.in_result  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      bus.in_c_out   = 1'($urandom);
      bus.in_a_sign  = 1'($urandom);
      bus.in_b_sign  = 1'($urandom);
      bus.in_dest    = 4'($urandom);
      bus.in_flag_we = 1'($urandom);
      bus.out_ready  = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.in_valid = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
# alu_flag_stage

Execute-to-writeback pipeline stage placed directly downstream of the 16-bit ALU. It captures each ALU result with its destination register and derives the Z/N/C/V flags. It keeps the architectural flag register and returns the committed carry to the ALU `c_in`. A 2-entry elastic buffer with a valid/ready handshake decouples the ALU from writeback stalls.

## Interface
- `DATA_W`, 16, ALU result width
- `DEST_W`, 4, destination register index width
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `flush` in 1: discard all buffered entries; flag register untouched
- `in_valid` in 1: ALU result presented
- `in_ready` out 1: stage can accept this cycle
- `in_result` in DATA_W: ALU `out`
- `in_c_out` in 1: ALU `c_out`
- `in_sel` in 4: ALU op select used for this result
- `in_a_sign`, `in_b_sign` in 1 each: bit 15 of ALU operands a and b
- `in_dest` in DEST_W: destination register index
- `in_flag_we` in 1: this op updates the flag register
- `out_valid` out 1: head entry valid
- `out_ready` in 1: writeback consumes head
- `out_result` out DATA_W, `out_dest` out DEST_W: head entry fields
- `out_flags` out 4: head entry flags {Z,N,C,V}
- `flags` out 4: architectural flag register {Z,N,C,V}
- `carry_fb` out 1: equals `flags[1]` (C); drives ALU `c_in`

## Operation
- Accept: `in_valid && in_ready`. Pop: `out_valid && out_ready`.
- `in_ready = (count < 2) && !flush`. `out_valid = (count != 0)`.
- Occupancy FSM: EMPTY(0), ONE(1), TWO(2).
  - Accept only: count+1.
  - Pop only: count-1.
  - Accept and pop in ONE: stays ONE; the new entry becomes head on the next cycle.
  - Accept is impossible in TWO.
- Entries leave in strict FIFO order. Head fields are driven directly from storage, with no combinational path from `in_*` to `out_*`.
- Flag derivation for an accepted op, with r = `in_result`:
  - Z = (r == 0). N = r[15].
  - For sel 0000 (add):
    - C = `in_c_out`.
    - V = (a_sign == b_sign) && (r[15] != a_sign).
  - For sel 0001 (a-b):
    - C = `in_c_out`.
    - V = (a_sign != b_sign) && (r[15] != a_sign).
  - For sel 1101 (b-a):
    - C = `in_c_out`.
    - V = (b_sign != a_sign) && (r[15] != b_sign).
  - For all other sel: C = current `flags` C (preserved) and V = 0.
- The derived {Z,N,C,V} is stored in the entry as `out_flags`.
- If `in_flag_we`, the `flags` register is written with the derived value on the accept edge. Otherwise `flags` holds.
- Flags commit at accept, not at pop, so back-to-back carry-chained ALU ops see the updated `carry_fb` in the following cycle.
- Flush: on an edge with `flush`=1, count → 0. No accept occurs that cycle because `in_ready` is 0. A pop presented that same cycle is dropped. `flags` holds.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - count = 0.
  - `out_valid`, `out_result`, `out_dest`, `out_flags`, `flags`, `carry_fb` all = 0.
  - `in_ready` = 1 after reset deasserts, when `flush`=0.
- Assertion of `rst_n`=0 mid-transfer drops all entries immediately without waiting for a clock edge.
- Latency: accepted at edge N → `out_valid`=1 with that entry after edge N.
- Throughput: 1 op/cycle with `out_ready` held high.
- Capacity: 2 entries of stall absorption. `in_ready` drops the cycle after the second unpopped accept.
- `flags`/`carry_fb` change on the edge of an accepting `in_flag_we` op. The value is visible to the ALU in the same cycle the entry first appears at the output.
- `out_*` is stable while `out_valid && !out_ready`, until a pop, flush, or reset.

## Test plan
- Add overflow:
  - Stimulus: sel=0000, r=16'h8000, a_sign=0, b_sign=0, c_out=0, flag_we=1, dest=3.
  - Required: next cycle `out_flags`={Z0,N1,C0,V1}, `out_dest`=3, `carry_fb`=0.
- Carry feedback:
  - Stimulus: sel=0000, r=16'h0000, c_out=1, flag_we=1, then sel=0010 (OR), r=16'h00F0.
  - Required: first entry flags {1,0,1,0}; `carry_fb`=1 from the next cycle. Second entry flags {0,0,1,0}, with C preserved and V=0.
- Backpressure:
  - Stimulus: hold `out_ready`=0 and accept results 1, 2.
  - Required: `in_ready`=0 after the second accept.
  - Stimulus: raise `out_ready`.
  - Required: pops 1 then 2, in order; `in_ready` returns to 1 the cycle after the first pop.
- Streaming:
  - Stimulus: 8 consecutive valid ops with `out_ready`=1.
  - Required: `in_ready` stays 1; outputs appear in order, one cycle after each accept.
- Flush with simultaneous input:
  - Stimulus: count=2, assert `flush` together with `in_valid`.
  - Required: `in_ready`=0; next cycle `out_valid`=0; `flags` unchanged.
- Async reset mid-operation:
  - Stimulus: count=1, `flags`=4'b1010; pulse `rst_n` low between clock edges.
  - Required: `out_valid`, `flags`, `carry_fb` go to 0 immediately, before the next edge.
